wddl_rail_decoder: RTL and testbench

- Converts a WDDL dual-rail byte bus (True/False rails, e.g. a dual-rail XOR tree output) back to a single-rail byte at the datapath boundary.
- Drives the precharge/evaluate phase control to the upstream dual-rail logic.
- Performs completion detection and validates the precharge spacer and rail complementarity.
- Hands the decoded byte downstream over a valid/ready handshake.

---
 rtl/wddl_rail_decoder_pkg.sv | 16 +
 rtl/wddl_completion_detect.sv | 19 +
 rtl/wddl_rail_decoder.sv | 121 ++++++++++++
 tb/tb_wddl_rail_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wddl_rail_decoder_pkg.sv
// Shared definitions for the WDDL dual-rail to single-rail boundary:
// data width, FSM state encoding and default timing parameters.
package wddl_rail_decoder_pkg;

    localparam int BYTE             = 8;
    localparam int EVAL_MIN_DEFAULT = 2;
    localparam int TIMEOUT_DEFAULT  = 15;

    // 2'd3 is unreachable and is decoded as PRE by the FSM.
    typedef enum logic [1:0] {
        PRE  = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/wddl_completion_detect.sv
// Combinational completion detection for a dual-rail bus: all-zero spacer,
// fully complementary codeword, and any rail pair driven 1/1.
module wddl_completion_detect
    import wddl_rail_decoder_pkg::*;
#(
    parameter int W = BYTE
) (
    input  logic [W-1:0] in_t,
    input  logic [W-1:0] in_f,
    output logic         spacer,
    output logic         complete,
    output logic         illegal
);

    assign spacer   = ~|(in_t | in_f);
    assign complete = &(in_t ^ in_f);
    assign illegal  = |(in_t & in_f);

endmodule

// File: rtl/wddl_rail_decoder.sv
// Drives precharge/evaluate to upstream WDDL logic, samples the first legal
// codeword after the settling margin and hands it out over valid/ready.
module wddl_rail_decoder
    import wddl_rail_decoder_pkg::*;
#(
    parameter int EVAL_MIN = EVAL_MIN_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BYTE-1:0] In_T,
    input  logic [BYTE-1:0] In_F,
    input  logic            start,
    output logic            pre_en,
    output logic            busy,
    output logic [BYTE-1:0] Out,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            err_clr,
    output logic            err_pre,
    output logic            err_rail,
    output logic            err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic spacer, complete, illegal;

    wddl_completion_detect #(.W(BYTE)) u_detect (
        .in_t     (In_T),
        .in_f     (In_F),
        .spacer   (spacer),
        .complete (complete),
        .illegal  (illegal)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BYTE-1:0]  out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_pre_q, err_pre_d;
    logic             err_rail_q, err_rail_d;
    logic             err_timeout_q, err_timeout_d;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        // Clear first, then let any error event below override it.
        err_pre_d     = err_clr ? 1'b0 : err_pre_q;
        err_rail_d    = err_clr ? 1'b0 : err_rail_q;
        err_timeout_d = err_clr ? 1'b0 : err_timeout_q;

        case (state_q)
            EVAL: begin
                cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
                if (illegal) begin
                    err_rail_d = 1'b1;
                    state_d    = PRE;
                end else if (complete && cnt_q >= CNT_W'(EVAL_MIN - 1)) begin
                    out_d       = In_T;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = PRE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = PRE;
                end
            end
            default: begin
                state_d = PRE;
                if (start) begin
                    if (spacer) begin
                        state_d = EVAL;
                        cnt_d   = '0;
                    end else begin
                        err_pre_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PRE;
            cnt_q         <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            err_pre_q     <= 1'b0;
            err_rail_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            err_pre_q     <= err_pre_d;
            err_rail_q    <= err_rail_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Decoded straight from the state flop so reset forces precharge at once.
    assign pre_en      = (state_q != EVAL);
    assign busy        = (state_q == EVAL) || (state_q == HOLD);
    assign Out         = out_q;
    assign out_valid   = out_valid_q;
    assign err_pre     = err_pre_q;
    assign err_rail    = err_rail_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_wddl_rail_decoder.sv
// Directed bench for wddl_rail_decoder: table of evaluate codewords plus
// hand-written backpressure, dirty-spacer, timeout and async-reset sequences.
module tb_wddl_rail_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] In_T, In_F;
    logic       start, out_ready, err_clr;
    logic       pre_en, busy, out_valid;
    logic [7:0] Out;
    logic       err_pre, err_rail, err_timeout;

    int checks   = 0;
    int failures = 0;

    wddl_rail_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .In_T        (In_T),
        .In_F        (In_F),
        .start       (start),
        .pre_en      (pre_en),
        .busy        (busy),
        .Out         (Out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .err_pre     (err_pre),
        .err_rail    (err_rail),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] t;
        logic [7:0] f;
        logic       exp_valid;
        logic [7:0] exp_out;
        logic       exp_rail;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{t: 8'hA5, f: 8'h5A, exp_valid: 1'b1, exp_out: 8'hA5, exp_rail: 1'b0};
        vecs[1] = '{t: 8'h00, f: 8'hFF, exp_valid: 1'b1, exp_out: 8'h00, exp_rail: 1'b0};
        vecs[2] = '{t: 8'hFF, f: 8'h00, exp_valid: 1'b1, exp_out: 8'hFF, exp_rail: 1'b0};
        vecs[3] = '{t: 8'h3C, f: 8'hC3, exp_valid: 1'b1, exp_out: 8'h3C, exp_rail: 1'b0};
        vecs[4] = '{t: 8'hFF, f: 8'h01, exp_valid: 1'b0, exp_out: 8'h00, exp_rail: 1'b1};
        vecs[5] = '{t: 8'h81, f: 8'h81, exp_valid: 1'b0, exp_out: 8'h00, exp_rail: 1'b1};

        rst = 1'b1; In_T = 8'h00; In_F = 8'h00;
        start = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        #3;
        check("reset pre_en", pre_en, 1);
        check("reset busy", busy, 0);
        check("reset out", Out, 8'h00);
        check("reset out_valid", out_valid, 0);
        check("reset errs", {err_pre, err_rail, err_timeout}, 3'b000);
        step();
        rst = 1'b0;
        step();

        // Table: spacer + start, codeword from cycle 1, ready on capture.
        foreach (vecs[i]) begin
            start = 1'b1;
            step();                                   // edge 0
            start = 1'b0;
            In_T = vecs[i].t; In_F = vecs[i].f;
            check($sformatf("v%0d eval pre_en", i), pre_en, 0);
            check($sformatf("v%0d eval busy", i), busy, 1);
            step();                                   // edge 1
            check($sformatf("v%0d edge1 valid", i), out_valid, 0);
            check($sformatf("v%0d edge1 err_rail", i), err_rail, vecs[i].exp_rail);
            if (vecs[i].exp_valid) begin
                step();                               // edge 2
                check($sformatf("v%0d valid", i), out_valid, 1);
                check($sformatf("v%0d out", i), Out, vecs[i].exp_out);
                check($sformatf("v%0d hold pre_en", i), pre_en, 1);
                In_T = 8'h00; In_F = 8'h00;
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                check($sformatf("v%0d after hs valid", i), out_valid, 0);
                check($sformatf("v%0d after hs busy", i), busy, 0);
            end else begin
                In_T = 8'h00; In_F = 8'h00;
                check($sformatf("v%0d abort pre_en", i), pre_en, 1);
                step();
                check($sformatf("v%0d abort no valid", i), out_valid, 0);
                check($sformatf("v%0d abort busy", i), busy, 0);
            end
            clear_errors();
            check($sformatf("v%0d errs cleared", i), {err_pre, err_rail, err_timeout}, 3'b000);
        end

        // Backpressure: Out held, start ignored while in HOLD.
        start = 1'b1;
        step();
        start = 1'b0;
        In_T = 8'hA5; In_F = 8'h5A;
        step();
        step();
        In_T = 8'h00; In_F = 8'h00;
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            step();
            check("bp valid held", out_valid, 1);
            check("bp out held", Out, 8'hA5);
            check("bp busy", busy, 1);
            check("bp pre_en", pre_en, 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release valid", out_valid, 0);
        check("bp release busy", busy, 0);
        check("bp out retained", Out, 8'hA5);

        // Dirty spacer, then set-wins-over-clear.
        In_T = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        check("dirty err_pre", err_pre, 1);
        check("dirty pre_en", pre_en, 1);
        check("dirty busy", busy, 0);
        step();
        check("dirty stays pre", busy, 0);
        clear_errors();
        check("dirty cleared", err_pre, 0);
        err_clr = 1'b1; start = 1'b1;
        step();
        err_clr = 1'b0; start = 1'b0;
        check("set beats clear", err_pre, 1);
        In_T = 8'h00;
        clear_errors();
        check("set beats clear cleared", err_pre, 0);

        // Timeout: incomplete codeword held for the full window.
        start = 1'b1;
        step();                                       // entry edge
        start = 1'b0;
        In_T = 8'h0F; In_F = 8'h00;
        for (int c = 1; c < 15; c++) begin
            step();
            if (err_timeout !== 1'b0 || pre_en !== 1'b0)
                check($sformatf("timeout early c%0d", c), {err_timeout, pre_en}, 2'b00);
        end
        check("timeout still eval", pre_en, 0);
        step();                                       // 15th edge after entry
        check("timeout err", err_timeout, 1);
        check("timeout pre_en", pre_en, 1);
        check("timeout no valid", out_valid, 0);
        In_T = 8'h00;
        clear_errors();

        // Async reset while in HOLD.
        start = 1'b1;
        step();
        start = 1'b0;
        In_T = 8'hA5; In_F = 8'h5A;
        step();
        step();
        check("rst pre hold valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", out_valid, 0);
        check("async rst out", Out, 8'h00);
        check("async rst pre_en", pre_en, 1);
        check("async rst busy", busy, 0);
        step();
        rst = 1'b0;
        In_T = 8'h00; In_F = 8'h00;
        step();
        check("post rst idle", {busy, out_valid}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
